// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential digit multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int unsigned shift_amt(
    input int unsigned i,
    input int unsigned j,
    input int unsigned a_dig,
    input int unsigned b_dig
  );
    return i * a_dig + j * b_dig;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// Start/busy/done controller with A (inner) and B (outer) digit counters.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int NA = 4,
  parameter int NB = 2,
  parameter int IW = 2,
  parameter int JW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [IW-1:0] a_idx,
  output logic [JW-1:0] b_idx,
  output logic          clr_prod,
  output logic          upd_prod,
  output logic          busy,
  output logic          done,
  output logic          ready
);

  localparam logic [IW-1:0] A_LAST = IW'(NA - 1);
  localparam logic [JW-1:0] B_LAST = JW'(NB - 1);

  state_t state, state_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    clr_prod = 1'b0;
    upd_prod = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          clr_prod = 1'b1;
          state_n  = CALC;
        end
      end
      CALC: begin
        busy     = 1'b1;
        upd_prod = 1'b1;
        if (a_idx == A_LAST && b_idx == B_LAST)
          state_n = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          clr_prod = 1'b1;
          state_n  = CALC;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A digit index runs fastest; B index advances on each A wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_idx <= '0;
      b_idx <= '0;
    end else if (clr_prod) begin
      a_idx <= '0;
      b_idx <= '0;
    end else if (upd_prod) begin
      if (a_idx == A_LAST) begin
        a_idx <= '0;
        b_idx <= (b_idx == B_LAST) ? '0 : b_idx + 1'b1;
      end else begin
        a_idx <= a_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_seq_param.sv
// Parametrised sequential unsigned multiplier: one digit product per cycle
// is shifted into place and accumulated into the product register.
module mult_seq_param
  import mult_seq_pkg::*;
#(
  parameter int A_W   = 32,
  parameter int B_W   = 32,
  parameter int A_DIG = 8,
  parameter int B_DIG = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int NA    = A_W / A_DIG;
  localparam int NB    = B_W / B_DIG;
  localparam int P_W   = A_W + B_W;
  localparam int PP_W  = A_DIG + B_DIG;
  localparam int IW    = (NA > 1) ? $clog2(NA) : 1;
  localparam int JW    = (NB > 1) ? $clog2(NB) : 1;

  if (A_W % A_DIG != 0) begin : g_bad_a_dig
    $error("A_W must be a multiple of A_DIG");
  end
  if (B_W % B_DIG != 0) begin : g_bad_b_dig
    $error("B_W must be a multiple of B_DIG");
  end

  logic [IW-1:0]    a_idx;
  logic [JW-1:0]    b_idx;
  logic             clr_prod;
  logic             upd_prod;
  logic [A_W-1:0]   a_reg;
  logic [B_W-1:0]   b_reg;
  logic [A_DIG-1:0] a_dig;
  logic [B_DIG-1:0] b_dig;
  logic [PP_W-1:0]  pp;
  logic [P_W-1:0]   term;

  mult_seq_ctrl #(
    .NA(NA),
    .NB(NB),
    .IW(IW),
    .JW(JW)
  ) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a_idx   (a_idx),
    .b_idx   (b_idx),
    .clr_prod(clr_prod),
    .upd_prod(upd_prod),
    .busy    (busy),
    .done    (done),
    .ready   (ready)
  );

  always_comb begin
    a_dig = a_reg[int'(a_idx) * A_DIG +: A_DIG];
    b_dig = b_reg[int'(b_idx) * B_DIG +: B_DIG];
    pp    = {{B_DIG{1'b0}}, a_dig} * {{A_DIG{1'b0}}, b_dig};
    term  = P_W'(pp) << shift_amt(int'(a_idx), int'(b_idx), A_DIG, B_DIG);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      product <= '0;
    end else if (clr_prod) begin
      a_reg   <= a;
      b_reg   <= b;
      product <= '0;
    end else if (upd_prod) begin
      product <= product + term;
    end
  end

endmodule
